// File: rtl/shift_iter_nbit.sv
// shift_iter_nbit
//   Iterative multi-mode barrel shifter. One log2 shift stage is applied per
//   clock, so a request takes SHIFT_WIDTH cycles regardless of the amount.
//   Valid/ready handshakes are used on both the request and result sides.
//
// Parameters
//   WIDTH        operand/result width (>= 2)
//   SHIFT_WIDTH  shift-amount bits used; also the number of shift cycles
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   block is idle and can accept a request
//   A          operand
//   B          shift amount; only B[SHIFT_WIDTH-1:0] is used
//   MODE       00 logical right, 01 arithmetic right, 10 logical left,
//              11 rotate right
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   Y          result, taken straight from the data register
module shift_iter_nbit #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           MODE,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     Y
);

  localparam int unsigned W     = WIDTH;
  localparam int          STG_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       data_d;
  logic [SHIFT_WIDTH-1:0] amt_q;
  logic [1:0]             mode_q;
  logic [STG_W-1:0]       stage_q;
  logic                   out_valid_q;

  // Upper amount bits are deliberately ignored.
  logic unused_b_hi;
  generate
    if (SHIFT_WIDTH < WIDTH) begin : g_unused_b
      assign unused_b_hi = ^B[WIDTH-1:SHIFT_WIDTH];
    end else begin : g_no_unused_b
      assign unused_b_hi = 1'b0;
    end
  endgenerate

  // Value of data after applying the current stage's 2^stage shift.
  int unsigned sh;
  int unsigned rot;
  always_comb begin
    sh     = 32'd1 << stage_q;
    rot    = sh % W;
    data_d = data_q;
    if (amt_q[stage_q]) begin
      unique case (mode_q)
        2'b00:   data_d = data_q >> sh;
        2'b01:   data_d = $unsigned($signed(data_q) >>> sh);
        2'b10:   data_d = data_q << sh;
        // A shift by W yields zero, so rot==0 reduces to data_q unchanged.
        default: data_d = (data_q >> rot) | (data_q << (W - rot));
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      amt_q       <= '0;
      mode_q      <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= A;
            amt_q   <= B[SHIFT_WIDTH-1:0];
            mode_q  <= MODE;
            stage_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          if (stage_q == STG_W'(SHIFT_WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            stage_q <= stage_q + STG_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign Y         = data_q;

endmodule

// File: tb/tb_shift_iter_nbit.sv
module tb_shift_iter_nbit;

  localparam int SW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [1:0]  m32 = '0;
  logic        ir32, ov32;
  logic [31:0] y32;

  logic        iv24 = 1'b0, or24 = 1'b0;
  logic [23:0] a24 = '0, b24 = '0;
  logic [1:0]  m24 = '0;
  logic        ir24, ov24;
  logic [23:0] y24;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_iter_nbit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .MODE(m32),
    .out_valid(ov32), .out_ready(or32), .Y(y32)
  );

  shift_iter_nbit #(.WIDTH(24)) dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24),
    .A(a24), .B(b24), .MODE(m24),
    .out_valid(ov24), .out_ready(or24), .Y(y24)
  );

  // Reference: each output bit picked directly from the operand.
  function automatic logic [31:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [1:0] m);
    logic [31:0] r;
    int amt;
    logic sign;
    r    = '0;
    amt  = int'(b % 32);
    sign = a[w-1];
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i + amt < w) ? a[i+amt] : 1'b0;
        2'b01:   r[i] = (i + amt < w) ? a[i+amt] : sign;
        2'b10:   r[i] = (i >= amt) ? a[i-amt] : 1'b0;
        default: r[i] = a[(i+amt)%w];
      endcase
    end
    return r;
  endfunction

  function automatic logic get_ov(input bit s24);
    return s24 ? ov24 : ov32;
  endfunction
  function automatic logic get_ir(input bit s24);
    return s24 ? ir24 : ir32;
  endfunction
  function automatic logic [31:0] get_y(input bit s24);
    return s24 ? {8'h00, y24} : y32;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s24, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic v);
    if (s24) begin
      a24 = a[23:0]; b24 = b[23:0]; m24 = m; iv24 = v;
    end else begin
      a32 = a; b32 = b; m32 = m; iv32 = v;
    end
  endtask

  task automatic set_or(input bit s24, input logic v);
    if (s24) or24 = v; else or32 = v;
  endtask

  // Issue one request, check latency/result, optionally apply backpressure
  // with a competing request, then hand the result off.
  task automatic do_op(input bit s24, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [31:0] exp,
                       input int hold, input string tag);
    int n;
    logic [31:0] yh;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(get_ir(s24)), 32'd1);
    drive(s24, a, b, m, 1'b1);
    @(posedge clk); #1;
    drive(s24, $urandom, $urandom, 2'($urandom), 1'b0);
    n = 0;
    while (!get_ov(s24) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(SW));
    check({tag, " Y"}, get_y(s24), exp);
    check({tag, " busy"}, 32'(get_ir(s24)), 32'd0);
    yh = get_y(s24);
    for (int k = 0; k < hold; k++) begin
      drive(s24, $urandom, $urandom, 2'($urandom), 1'b1);
      @(posedge clk); #1;
      check({tag, " hold ov"}, 32'(get_ov(s24)), 32'd1);
      check({tag, " hold Y"}, get_y(s24), yh);
      check({tag, " hold rdy"}, 32'(get_ir(s24)), 32'd0);
    end
    drive(s24, '0, '0, 2'b00, 1'b0);
    set_or(s24, 1'b1);
    @(posedge clk); #1;
    set_or(s24, 1'b0);
    check({tag, " handoff ov"}, 32'(get_ov(s24)), 32'd0);
    check({tag, " handoff rdy"}, 32'(get_ir(s24)), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rm;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(ir32), 32'd0);
    check("rst ov", 32'(ov32), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready32", 32'(ir32), 32'd1);
    check("post-rst in_ready24", 32'(ir24), 32'd1);
    check("post-rst Y32", y32, 32'd0);
    check("post-rst Y24", {8'h00, y24}, 32'd0);

    // Directed, WIDTH=32
    do_op(1'b0, 32'h8000_0001, 32'd4,          2'b00, 32'h0800_0000, 0, "lsr");
    do_op(1'b0, 32'h8000_0000, 32'd31,         2'b01, 32'hFFFF_FFFF, 0, "asr31");
    do_op(1'b0, 32'h8000_0000, 32'h0000_0020,  2'b01, 32'h8000_0000, 0, "asr_amt0");
    do_op(1'b0, 32'h0000_0001, 32'd31,         2'b10, 32'h8000_0000, 0, "lsl31");
    do_op(1'b0, 32'h0000_0003, 32'd1,          2'b11, 32'h8000_0001, 0, "ror1");
    do_op(1'b0, 32'h1234_5678, 32'd4,          2'b00, 32'h0123_4567, 10, "backpressure");

    // After backpressure, the competing request must not have started
    repeat (3) begin
      @(posedge clk); #1;
      check("no queued req ov", 32'(ov32), 32'd0);
      check("no queued req rdy", 32'(ir32), 32'd1);
    end

    // Reset mid-operation at stage 2
    @(negedge clk);
    drive(1'b0, 32'hDEAD_BEEF, 32'd7, 2'b11, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst ov", 32'(ov32), 32'd0);
    check("midrst Y", y32, 32'd0);
    check("midrst rdy", 32'(ir32), 32'd1);
    repeat (8) begin
      @(posedge clk); #1;
      check("midrst no stale", 32'(ov32), 32'd0);
    end
    do_op(1'b0, 32'hFFFF_FFFF, 32'd8, 2'b00, 32'h00FF_FFFF, 0, "after_rst");

    // Directed, WIDTH=24
    do_op(1'b1, 32'h00FF_FFFF, 32'd30, 2'b00, 32'h0000_0000, 0, "w24 lsr30");
    do_op(1'b1, 32'h0080_0000, 32'd30, 2'b01, 32'h00FF_FFFF, 0, "w24 asr30");
    do_op(1'b1, 32'h0000_0001, 32'd25, 2'b11, 32'h0080_0000, 0, "w24 ror25");

    // Random against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rm = 2'($urandom);
      if (i % 4 == 0) rb = rb & 32'h0000_001F;
      do_op(1'b0, ra, rb, rm, model(32, ra, rb, rm), (i % 7 == 0) ? 2 : 0, "rand32");
    end
    for (int i = 0; i < 40; i++) begin
      ra = $urandom & 32'h00FF_FFFF;
      rb = $urandom & 32'h00FF_FFFF;
      rm = 2'($urandom);
      if (i % 3 == 0) rb = 32'(24 + (i % 8));
      do_op(1'b1, ra, rb, rm, model(24, ra, rb, rm), 0, "rand24");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
